ans_decoder: RTL and testbench

- rANS decoder; the inverse of the team's ans_encoder.
- It is loaded with the encoder's final state and a symbol count.
- It emits decoded symbols in reverse encode order and pulls SYM_WIDTH-bit renormalization chunks from the compressed stream (LIFO order relative to encoder output).
- Symbol lookup is done by an external combinational frequency table, driven from the slot output.

---
 rtl/ans_decoder.sv | 179 +++++++++++++++++
 tb/tb_ans_decoder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ans_decoder.sv
// rANS decoder: loaded with an encoder's final state, emits symbols in reverse order and
// pulls SYM_WIDTH-bit renormalization chunks while the state is below the normalized range.
module ans_decoder #(
  parameter int SYM_WIDTH   = 4,
  parameter int CNT_WIDTH   = 5,
  parameter int STATE_WIDTH = 8,
  parameter int TOTAL_LOG2  = 4,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           load,
  input  logic [STATE_WIDTH-1:0]         state_in,
  input  logic [LEN_WIDTH-1:0]           num_syms,
  output logic [TOTAL_LOG2-1:0]          slot,
  input  logic [SYM_WIDTH-1:0]           s_sym,
  input  logic [CNT_WIDTH-1:0]           s_count,
  input  logic [SYM_WIDTH+CNT_WIDTH-1:0] s_cumulative,
  input  logic [SYM_WIDTH-1:0]           in,
  input  logic                           in_vld,
  output logic                           in_rdy,
  output logic [SYM_WIDTH-1:0]           out,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic                           done,
  output logic                           err
);

  localparam int PW = STATE_WIDTH + CNT_WIDTH;
  localparam int RW = SYM_WIDTH + CNT_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_OUT_WAIT, S_RENORM, S_DONE
  } fsm_t;

  fsm_t                   fsm_q, fsm_d;
  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [SYM_WIDTH-1:0]   out_q, out_d;
  logic                   out_vld_q, out_vld_d;
  logic                   in_rdy_q, in_rdy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [RW-1:0]                      slot_ext, lo_ext, hi_ext;
  logic                               tbl_bad;
  logic [STATE_WIDTH+SYM_WIDTH-1:0]   shifted_full;
  logic [STATE_WIDTH-1:0]             renorm_state;

  // x' = count * (x / T) + (x mod T) - cumulative, kept to STATE_WIDTH bits
  function automatic logic [STATE_WIDTH-1:0] decode_step(
    input logic [STATE_WIDTH-1:0]         x,
    input logic [CNT_WIDTH-1:0]           cnt,
    input logic [SYM_WIDTH+CNT_WIDTH-1:0] cum
  );
    logic [PW-1:0] full;
    full = PW'(cnt) * PW'(x >> TOTAL_LOG2) + PW'(x[TOTAL_LOG2-1:0]) - PW'(cum);
    return full[STATE_WIDTH-1:0];
  endfunction

  function automatic logic below_t(input logic [STATE_WIDTH-1:0] x);
    return x < (STATE_WIDTH'(1) << TOTAL_LOG2);
  endfunction

  assign slot         = state_q[TOTAL_LOG2-1:0];
  assign slot_ext     = RW'(state_q[TOTAL_LOG2-1:0]);
  assign lo_ext       = RW'(s_cumulative);
  assign hi_ext       = lo_ext + RW'(s_count);
  assign tbl_bad      = (s_count == '0) || (slot_ext < lo_ext) || (slot_ext >= hi_ext);
  assign shifted_full = {state_q, in};
  assign renorm_state = shifted_full[STATE_WIDTH-1:0];

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rem_d     = rem_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    in_rdy_d  = in_rdy_q;
    done_d    = done_q;
    err_d     = err_q;
    if (ena) begin
      case (fsm_q)
        S_IDLE, S_DONE: begin
          if (load) begin
            state_d = state_in;
            rem_d   = num_syms;
            err_d   = 1'b0;
            if (num_syms == '0) begin
              fsm_d  = S_DONE;
              done_d = 1'b1;
            end else begin
              fsm_d  = S_DECODE;
              done_d = 1'b0;
            end
          end
        end
        S_DECODE: begin
          if (tbl_bad) begin
            err_d  = 1'b1;
            fsm_d  = S_DONE;
            done_d = 1'b1;
          end else begin
            state_d   = decode_step(state_q, s_count, s_cumulative);
            out_d     = s_sym;
            out_vld_d = 1'b1;
            rem_d     = rem_q - LEN_WIDTH'(1);
            fsm_d     = S_OUT_WAIT;
          end
        end
        S_OUT_WAIT: begin
          if (out_rdy) begin
            out_vld_d = 1'b0;
            if (below_t(state_q)) begin
              fsm_d    = S_RENORM;
              in_rdy_d = 1'b1;
            end else if (rem_q == '0) begin
              fsm_d  = S_DONE;
              done_d = 1'b1;
            end else begin
              fsm_d = S_DECODE;
            end
          end
        end
        S_RENORM: begin
          if (in_vld && in_rdy_q) begin
            state_d = renorm_state;
            // Leave only once the refilled state is back in the normalized range
            if (!below_t(renorm_state)) begin
              in_rdy_d = 1'b0;
              if (rem_q == '0) begin
                fsm_d  = S_DONE;
                done_d = 1'b1;
              end else begin
                fsm_d = S_DECODE;
              end
            end
          end
        end
        default: begin
          fsm_d     = S_IDLE;
          out_vld_d = 1'b0;
          in_rdy_d  = 1'b0;
          done_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      state_q   <= '0;
      rem_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      in_rdy_q  <= in_rdy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign in_rdy  = in_rdy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ans_decoder.sv
// Scoreboard bench for ans_decoder: a high-level rANS reference model predicts symbols,
// chunk usage and final state; a negedge monitor pops and compares on each symbol handshake.
module tb_ans_decoder;

  logic       clk = 1'b0;
  logic       rst, ena, load;
  logic [7:0] state_in, num_syms;
  logic [3:0] slot, s_sym, in, out;
  logic [4:0] s_count;
  logic [8:0] s_cumulative;
  logic       in_vld, in_rdy, out_vld, out_rdy, done, err;

  always #5 clk = ~clk;

  ans_decoder #(.SYM_WIDTH(4), .CNT_WIDTH(5), .STATE_WIDTH(8), .TOTAL_LOG2(4), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .state_in(state_in), .num_syms(num_syms),
    .slot(slot), .s_sym(s_sym), .s_count(s_count), .s_cumulative(s_cumulative),
    .in(in), .in_vld(in_vld), .in_rdy(in_rdy), .out(out), .out_vld(out_vld),
    .out_rdy(out_rdy), .done(done), .err(err)
  );

  // frequency table
  logic [3:0] tbl_sym [16];
  int         tbl_cnt [16];
  int         tbl_cum [16];
  logic       bad_tbl = 1'b0;
  assign s_sym        = tbl_sym[slot];
  assign s_count      = bad_tbl ? 5'd0 : 5'(tbl_cnt[slot]);
  assign s_cumulative = 9'(tbl_cum[slot]);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard and environment knobs
  logic [3:0] sb_q[$];
  logic [3:0] chunk_q[$];
  int         ch_list [64];
  int         consumed = 0;
  int         n_sym_seen = 0;
  int         rdy_rises = 0;
  logic       force_low = 1'b0, rdy_rand = 1'b0, ena_rand = 1'b0, vld_rand = 1'b0;
  logic       hs_in_s = 1'b0, ena_s = 1'b0, hold_prev = 1'b0, in_rdy_prev = 1'b0;
  logic [3:0] prev_out = 4'd0;

  // sink
  initial out_rdy = 1'b1;
  always begin
    tick();
    out_rdy = force_low ? 1'b0 : (rdy_rand ? (($urandom % 3) != 0) : 1'b1);
  end

  // random clock-enable
  always begin
    tick();
    if (ena_rand) ena = (($urandom % 4) != 0);
  end

  // chunk source: holds each chunk until consumed
  always @(negedge clk) begin
    hs_in_s = in_vld && in_rdy && ena && !rst;
    ena_s   = ena;
  end
  always begin
    tick();
    if (hs_in_s) begin
      void'(chunk_q.pop_front());
      consumed++;
      in_vld = 1'b0;
    end
    if (chunk_q.size() == 0) in_vld = 1'b0;
    else if (in_vld) in = chunk_q[0];
    else if (!vld_rand || ($urandom % 2) == 1) begin
      in     = chunk_q[0];
      in_vld = 1'b1;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      hold_prev   = 1'b0;
      in_rdy_prev = 1'b0;
    end else begin
      check("vld_rdy_exclusive", int'(out_vld && in_rdy), 0);
      if (hold_prev) begin
        check("hold_out_vld", int'(out_vld), 1);
        check("hold_out", int'(out), int'(prev_out));
      end
      if (out_vld && out_rdy && ena) begin
        n_sym_seen++;
        check("sb_has_entry", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) check("sym", int'(out), int'(sb_q.pop_front()));
      end
      if (in_rdy && !in_rdy_prev) rdy_rises++;
      in_rdy_prev = in_rdy;
      hold_prev   = out_vld && !(out_rdy && ena);
      prev_out    = out;
    end
  end

  // reference model: plain rANS arithmetic over the table arrays
  int         m_x, m_used;
  logic       m_err;
  logic [3:0] m_syms[$];

  task automatic model(input int x0, input int n);
    int x, s, c, cu;
    x = x0; m_used = 0; m_err = 1'b0; m_syms.delete();
    for (int i = 0; i < n; i++) begin
      s  = x % 16;
      c  = bad_tbl ? 0 : tbl_cnt[s];
      cu = tbl_cum[s];
      if (c == 0 || s < cu || s >= cu + c) begin
        m_err = 1'b1;
        break;
      end
      x = (c * (x / 16) + s - cu) % 256;
      m_syms.push_back(tbl_sym[s]);
      while (x < 16 && m_used < 64) begin
        x = (x * 16 + ch_list[m_used]) % 256;
        m_used++;
      end
    end
    m_x = x;
  endtask

  task automatic set_ab();
    for (int i = 0; i < 16; i++) begin
      tbl_sym[i] = (i < 12) ? 4'hA : 4'hB;
      tbl_cnt[i] = (i < 12) ? 12 : 4;
      tbl_cum[i] = (i < 12) ? 0 : 12;
    end
  endtask

  task automatic rand_table();
    int         start;
    logic [3:0] sym;
    start = 0;
    sym   = 4'($urandom);
    for (int s = 1; s <= 16; s++) begin
      if (s == 16 || ($urandom % 3) == 0) begin
        for (int j = start; j < s; j++) begin
          tbl_sym[j] = sym;
          tbl_cnt[j] = s - start;
          tbl_cum[j] = start;
        end
        start = s;
        sym   = 4'($urandom);
      end
    end
  endtask

  task automatic rand_chunks();
    for (int i = 0; i < 64; i++) ch_list[i] = $urandom_range(1, 15);
  endtask

  task automatic start_txn(input int st, input int n);
    int guard;
    chunk_q.delete();
    for (int i = 0; i < 64; i++) chunk_q.push_back(4'(ch_list[i]));
    consumed   = 0;
    n_sym_seen = 0;
    rdy_rises  = 0;
    model(st, n);
    foreach (m_syms[i]) sb_q.push_back(m_syms[i]);
    state_in = 8'(st);
    num_syms = 8'(n);
    load     = 1'b1;
    guard    = 0;
    do begin
      tick();
      guard++;
    end while (!ena_s && guard < 100);
    load = 1'b0;
  endtask

  task automatic finish_txn(input string tag);
    int guard;
    guard = 0;
    while (!done && guard < 3000) begin
      tick();
      guard++;
    end
    check({tag, "_done_in_time"}, int'(done), 1);
    #1;
    check({tag, "_err"}, int'(err), int'(m_err));
    check({tag, "_final_slot"}, int'(slot), m_x % 16);
    check({tag, "_chunks_used"}, consumed, m_used);
    check({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  task automatic wait_high_out_vld(input string tag);
    int guard;
    guard = 0;
    while (!out_vld && guard < 200) begin
      tick();
      guard++;
    end
    check({tag, "_out_vld_seen"}, int'(out_vld), 1);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; load = 1'b0; state_in = 8'd0; num_syms = 8'd0;
    in = 4'd0; in_vld = 1'b0;
    set_ab();
    rand_chunks();
    repeat (3) tick();
    check("rst_out", int'(out), 0);
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_in_rdy", int'(in_rdy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_slot", int'(slot), 0);
    rst = 1'b0;
    tick();

    // six A symbols, then one chunk 0x7 -> state 215
    ch_list[0] = 7;
    start_txn(8'h35, 6);
    finish_txn("r1");
    check("r1_slot_215", int'(slot), 7);
    check("r1_syms_seen", n_sym_seen, 6);
    check("r1_rdy_pulses", rdy_rises, 1);

    // backpressure on the first symbol
    force_low = 1'b1;
    start_txn(8'h35, 6);
    wait_high_out_vld("bp");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_vld", int'(out_vld), 1);
      check("bp_out", int'(out), 4'hA);
      check("bp_slot_41", int'(slot), 9);
    end
    force_low = 1'b0;
    finish_txn("bp");
    check("bp_slot_215", int'(slot), 7);

    // B then renorm with 0x3, ignored load during DECODE, ena low in RENORM
    rand_chunks();
    ch_list[0] = 3;
    start_txn(8'h2E, 2);
    state_in = 8'hFF; num_syms = 8'd9; load = 1'b1;
    tick();
    load = 1'b0;
    for (int g = 0; g < 100 && !in_rdy; g++) tick();
    check("r2_in_rdy_seen", int'(in_rdy), 1);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r2_ena_in_rdy", int'(in_rdy), 1);
      check("r2_ena_out_vld", int'(out_vld), 0);
      check("r2_ena_slot_10", int'(slot), 10);
      check("r2_ena_consumed", consumed, 0);
      check("r2_ena_done", int'(done), 0);
    end
    ena = 1'b1;
    finish_txn("r2");
    check("r2_slot_123", int'(slot), 11);
    check("r2_syms_seen", n_sym_seen, 2);

    // zero-length load
    start_txn(8'h80, 0);
    finish_txn("zero");
    check("zero_syms_seen", n_sym_seen, 0);

    // table inconsistency
    bad_tbl = 1'b1;
    start_txn(8'h35, 6);
    finish_txn("bad");
    check("bad_err_set", int'(err), 1);
    check("bad_syms_seen", n_sym_seen, 0);
    bad_tbl = 1'b0;
    ch_list[0] = 7;
    start_txn(8'h35, 6);
    check("bad_err_cleared", int'(err), 0);
    finish_txn("bad_recover");

    // asynchronous reset in OUT_WAIT
    force_low = 1'b1;
    start_txn(8'h35, 6);
    wait_high_out_vld("arst");
    #1 rst = 1'b1;
    #1;
    check("arst_out_vld", int'(out_vld), 0);
    check("arst_in_rdy", int'(in_rdy), 0);
    check("arst_done", int'(done), 0);
    sb_q.delete();
    chunk_q.delete();
    force_low = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("arst_slot", int'(slot), 0);
    check("arst_idle_done", int'(done), 0);
    check("arst_idle_out_vld", int'(out_vld), 0);

    // randomized tables, states, lengths and flow control
    for (int t = 0; t < 40; t++) begin
      rand_table();
      rand_chunks();
      rdy_rand = (t % 2) == 1;
      vld_rand = (t % 3) != 0;
      ena_rand = (t % 4) >= 2;
      start_txn($urandom_range(0, 255), $urandom_range(0, 20));
      finish_txn("rand");
      ena_rand = 1'b0;
      rdy_rand = 1'b0;
      tick();
      ena = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
